// File: rtl/median_iter_ctrl.sv
// Pass sequencer for the quickselect median datapath: scans the buffer, partitions samples
// around the pivot, handshakes with the next-iteration logic. MEDIAN_ITER_LIMIT_EN bounds passes.
module median_iter_ctrl #(
  parameter int         BUFF_SIZE     = 1024,
  parameter int         BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
  parameter int         MEDIAN_POS    = BUFF_SIZE / 2,
  parameter logic [7:0] INIT_PIVOT    = 8'd127,
  parameter int         MAX_ITER      = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     mem_rd_en,
  output logic [BUFF_SIZE_BIT-2:0] mem_rd_addr,
  input  logic [7:0]               mem_rd_data,
  output logic                     up_next,
  input  logic [1:0]               case_in,
  output logic [BUFF_SIZE_BIT-1:0] lower_size,
  output logic [BUFF_SIZE_BIT-1:0] equal_size,
  output logic [BUFF_SIZE_BIT-1:0] larger_size,
  output logic [8:0]               max_lower,
  output logic [8:0]               min_lower,
  output logic [8:0]               max_larger,
  output logic [8:0]               min_larger,
  output logic [BUFF_SIZE_BIT-1:0] buff_size_samp,
  output logic [BUFF_SIZE_BIT-1:0] median_pos_samp,
  output logic [8:0]               pivot_samp,
  output logic [8:0]               second_median_samp,
  input  logic [7:0]               next_pivot,
  input  logic [7:0]               next_second_median,
  input  logic [BUFF_SIZE_BIT-1:0] next_buff_size,
  input  logic [BUFF_SIZE_BIT-1:0] next_median_pos,
  output logic [7:0]               median,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     iter_err
);

  typedef enum logic [2:0] {IDLE, PASS, DRAIN, UPDATE, CAPTURE, DONE} state_t;

  localparam logic [1:0] CASE_LOW  = 2'b00;
  localparam logic [1:0] CASE_EQ0  = 2'b01;
  localparam logic [1:0] CASE_EQ1  = 2'b10;
  localparam logic [1:0] CASE_LARG = 2'b11;

  localparam int                       ITER_W    = $clog2(MAX_ITER + 1);
  localparam logic [ITER_W-1:0]        ITER_SAT  = ITER_W'(MAX_ITER);
  localparam logic [BUFF_SIZE_BIT-2:0] ADDR_LAST = (BUFF_SIZE_BIT-1)'(BUFF_SIZE - 1);
  localparam logic [BUFF_SIZE_BIT-1:0] SIZE_INIT = BUFF_SIZE_BIT'(BUFF_SIZE);
  localparam logic [BUFF_SIZE_BIT-1:0] POS_INIT  = BUFF_SIZE_BIT'(MEDIAN_POS);
  localparam logic [BUFF_SIZE_BIT-1:0] CNT_ONE   = BUFF_SIZE_BIT'(1);
`ifdef MEDIAN_ITER_LIMIT_EN
  localparam logic [ITER_W-1:0]        ITER_LAST = ITER_W'(MAX_ITER - 1);
`endif

  state_t            state;
  logic [7:0]        lo, hi;
  logic [1:0]        case_q;
  logic [ITER_W-1:0] iter_cnt;
  logic              vld_p1;

  function automatic logic in_window(input logic [7:0] s, input logic [7:0] w_lo,
                                     input logic [7:0] w_hi);
    return (s >= w_lo) && (s <= w_hi);
  endfunction

  function automatic logic [8:0] ext9(input logic [7:0] s);
    return {1'b0, s};
  endfunction

  assign busy = (state != IDLE);
`ifndef MEDIAN_ITER_LIMIT_EN
  assign iter_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      lo                 <= 8'd0;
      hi                 <= 8'd255;
      case_q             <= CASE_LOW;
      iter_cnt           <= '0;
      vld_p1             <= 1'b0;
      mem_rd_en          <= 1'b0;
      mem_rd_addr        <= '0;
      up_next            <= 1'b0;
      lower_size         <= '0;
      equal_size         <= '0;
      larger_size        <= '0;
      max_lower          <= 9'd0;
      max_larger         <= 9'd0;
      min_lower          <= 9'd255;
      min_larger         <= 9'd255;
      pivot_samp         <= ext9(INIT_PIVOT);
      second_median_samp <= ext9(INIT_PIVOT);
      median_pos_samp    <= POS_INIT;
      buff_size_samp     <= SIZE_INIT;
      median             <= 8'd0;
      out_valid          <= 1'b0;
`ifdef MEDIAN_ITER_LIMIT_EN
      iter_err           <= 1'b0;
`endif
    end else begin
      vld_p1  <= mem_rd_en;
      up_next <= 1'b0;

      // Stage p1: the sample returned one cycle after its read strobe
      if (vld_p1 && in_window(mem_rd_data, lo, hi)) begin
        if (mem_rd_data < pivot_samp[7:0]) begin
          lower_size <= lower_size + CNT_ONE;
          if (ext9(mem_rd_data) > max_lower) max_lower <= ext9(mem_rd_data);
          if (ext9(mem_rd_data) < min_lower) min_lower <= ext9(mem_rd_data);
        end else if (mem_rd_data == pivot_samp[7:0]) begin
          equal_size <= equal_size + CNT_ONE;
        end else begin
          larger_size <= larger_size + CNT_ONE;
          if (ext9(mem_rd_data) > max_larger) max_larger <= ext9(mem_rd_data);
          if (ext9(mem_rd_data) < min_larger) min_larger <= ext9(mem_rd_data);
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            pivot_samp         <= ext9(INIT_PIVOT);
            second_median_samp <= ext9(INIT_PIVOT);
            median_pos_samp    <= POS_INIT;
            buff_size_samp     <= SIZE_INIT;
            lo                 <= 8'd0;
            hi                 <= 8'd255;
            iter_cnt           <= '0;
            lower_size  <= '0;  equal_size <= '0;  larger_size <= '0;
            max_lower   <= 9'd0; max_larger <= 9'd0;
            min_lower   <= 9'd255; min_larger <= 9'd255;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= '0;
            state       <= PASS;
          end
        end
        PASS: begin
          if (mem_rd_addr == ADDR_LAST) begin
            mem_rd_en <= 1'b0;
            state     <= DRAIN;
          end else begin
            mem_rd_addr <= mem_rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          up_next <= 1'b1;
          state   <= UPDATE;
        end
        UPDATE: begin
          case_q <= case_in;
          if (case_in == CASE_LOW)  hi <= pivot_samp[7:0] - 8'd1;
          if (case_in == CASE_LARG) lo <= pivot_samp[7:0] + 8'd1;
          state <= CAPTURE;
        end
        CAPTURE: begin
          pivot_samp         <= ext9(next_pivot);
          second_median_samp <= ext9(next_second_median);
          median_pos_samp    <= next_median_pos;
          buff_size_samp     <= next_buff_size;
          if (case_q == CASE_EQ0 || case_q == CASE_EQ1) begin
            median    <= next_pivot;
            out_valid <= 1'b1;
            state     <= DONE;
          end
`ifdef MEDIAN_ITER_LIMIT_EN
          else if (iter_cnt == ITER_LAST) begin
            median    <= next_pivot;
            out_valid <= 1'b1;
            iter_err  <= 1'b1;
            state     <= DONE;
          end
`endif
          else begin
            if (iter_cnt != ITER_SAT) iter_cnt <= iter_cnt + ITER_W'(1);
            lower_size  <= '0;  equal_size <= '0;  larger_size <= '0;
            max_lower   <= 9'd0; max_larger <= 9'd0;
            min_lower   <= 9'd255; min_larger <= 9'd255;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= '0;
            state       <= PASS;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
`ifdef MEDIAN_ITER_LIMIT_EN
            iter_err  <= 1'b0;
`endif
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_median_iter_ctrl.sv
// Bench for median_iter_ctrl: 1024x8 buffer, behavioural next-iteration logic, frame-level
// reference model and a per-cycle compare process.
module tb_median_iter_ctrl;

  localparam int BSB = 11;
`ifdef MEDIAN_ITER_LIMIT_EN
  localparam int MAX_IT = 1;
  localparam bit LIM    = 1'b1;
`else
  localparam int MAX_IT = 9;
  localparam bit LIM    = 1'b0;
`endif
  localparam logic [1:0] C_LOW = 2'b00, C_EQ0 = 2'b01, C_EQ1 = 2'b10, C_LARG = 2'b11;

  typedef struct packed {
    logic [1:0]  c;
    logic [7:0]  piv;
    logic [7:0]  sm;
    logic [10:0] size;
    logic [10:0] pos;
  } nxt_t;

  logic clk = 1'b0;
  logic rst_n, start, out_ready;
  logic busy, mem_rd_en, up_next, out_valid, iter_err;
  logic [BSB-2:0] mem_rd_addr;
  logic [7:0] mem_rd_data, median, next_pivot, next_second_median;
  logic [1:0] case_in;
  logic [BSB-1:0] lower_size, equal_size, larger_size, buff_size_samp, median_pos_samp;
  logic [BSB-1:0] next_buff_size, next_median_pos;
  logic [8:0] max_lower, min_lower, max_larger, min_larger, pivot_samp, second_median_samp;
  logic [7:0] mem [1024];

  int checks = 0, errors = 0;
  int cyc = 0, start_cyc = 0, pass_idx = 0;
  bit check_en = 1'b0, ov_prev = 1'b0;
  int exp_l[16], exp_e[16], exp_g[16], exp_maxl[16], exp_minl[16], exp_maxg[16], exp_ming[16];
  int exp_piv[16], exp_pos[16], exp_size[16], exp_sm[16];
  int exp_passes, exp_median, exp_err;

  median_iter_ctrl #(.MAX_ITER(MAX_IT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .up_next(up_next), .case_in(case_in),
    .lower_size(lower_size), .equal_size(equal_size), .larger_size(larger_size),
    .max_lower(max_lower), .min_lower(min_lower), .max_larger(max_larger), .min_larger(min_larger),
    .buff_size_samp(buff_size_samp), .median_pos_samp(median_pos_samp),
    .pivot_samp(pivot_samp), .second_median_samp(second_median_samp),
    .next_pivot(next_pivot), .next_second_median(next_second_median),
    .next_buff_size(next_buff_size), .next_median_pos(next_median_pos),
    .median(median), .out_valid(out_valid), .out_ready(out_ready), .iter_err(iter_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  // Next-iteration rule: pos is the 0-based index of the upper median inside the subset;
  // sm carries the value just below it when that value lies outside the subset.
  function automatic nxt_t next_iter(input int L, input int E, input int G, input int maxl,
                                     input int minl, input int maxg, input int ming,
                                     input int pos, input int pivot, input int sm);
    nxt_t n;
    int q, nb;
    n.c = C_EQ1; n.piv = 8'(pivot); n.sm = 8'(sm); n.size = 11'(L); n.pos = 11'(pos);
    if (pos < L) begin
      if (minl == maxl) begin
        if (pos == 0) begin n.c = C_EQ0; n.piv = 8'((minl + sm) / 2); end
        else          begin n.c = C_EQ1; n.piv = 8'(minl); end
      end else begin
        n.c = C_LOW; n.piv = 8'((minl + maxl) / 2);
      end
    end else if (pos < L + E) begin
      if (pos > L) n.c = C_EQ1;
      else begin
        nb = (L > 0) ? maxl : sm;
        n.c = C_EQ0; n.piv = 8'((pivot + nb) / 2);
      end
    end else begin
      q  = pos - L - E;
      nb = (E > 0) ? pivot : ((L > 0) ? maxl : sm);
      if (ming == maxg && q > 0) begin n.c = C_EQ1; n.piv = 8'(ming); end
      else begin
        n.c = C_LARG; n.piv = 8'(ming); n.size = 11'(G); n.pos = 11'(q);
        if (q == 0) n.sm = 8'(nb);
      end
    end
    return n;
  endfunction

  // Next-iteration logic stand-in: case is combinational, results registered on up_next
  nxt_t nx;
  always_comb nx = next_iter(int'(lower_size), int'(equal_size), int'(larger_size),
                             int'(max_lower), int'(min_lower), int'(max_larger), int'(min_larger),
                             int'(median_pos_samp), int'(pivot_samp), int'(second_median_samp));
  assign case_in = nx.c;
  always @(posedge clk) if (up_next) begin
    next_pivot         <= nx.piv;
    next_second_median <= nx.sm;
    next_buff_size     <= nx.size;
    next_median_pos    <= nx.pos;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: partition the whole buffer pass by pass
  task automatic model_run();
    int lo, hi, piv, pos, sm, p, s;
    int L, E, G, maxl, minl, maxg, ming;
    bit done;
    nxt_t n;
    lo = 0; hi = 255; piv = 127; pos = 512; sm = 127; p = 0; done = 1'b0;
    while (!done && p < 16) begin
      L = 0; E = 0; G = 0; maxl = 0; minl = 255; maxg = 0; ming = 255;
      for (int i = 0; i < 1024; i++) begin
        s = int'(mem[i]);
        if (s >= lo && s <= hi) begin
          if (s < piv) begin L++; if (s > maxl) maxl = s; if (s < minl) minl = s; end
          else if (s == piv) E++;
          else begin G++; if (s > maxg) maxg = s; if (s < ming) ming = s; end
        end
      end
      exp_l[p] = L; exp_e[p] = E; exp_g[p] = G;
      exp_maxl[p] = maxl; exp_minl[p] = minl; exp_maxg[p] = maxg; exp_ming[p] = ming;
      exp_piv[p] = piv; exp_pos[p] = pos; exp_sm[p] = sm;
      exp_size[p] = (p == 0) ? 1024 : exp_size[p];
      n = next_iter(L, E, G, maxl, minl, maxg, ming, pos, piv, sm);
      p++;
      if (n.c == C_EQ0 || n.c == C_EQ1) begin
        exp_median = int'(n.piv); exp_err = 0; done = 1'b1;
      end else if (LIM && p == MAX_IT) begin
        exp_median = int'(n.piv); exp_err = 1; done = 1'b1;
      end else begin
        if (n.c == C_LOW) hi = piv - 1; else lo = piv + 1;
        piv = int'(n.piv); pos = int'(n.pos); sm = int'(n.sm);
        if (p < 16) exp_size[p] = int'(n.size);
      end
    end
    exp_passes = p;
  endtask

  always @(negedge clk) begin
    if (rst_n && check_en) begin
      if (up_next) begin
        if (pass_idx < 16) begin
          chk("lower_size", int'(lower_size), exp_l[pass_idx]);
          chk("equal_size", int'(equal_size), exp_e[pass_idx]);
          chk("larger_size", int'(larger_size), exp_g[pass_idx]);
          chk("max_lower", int'(max_lower), exp_maxl[pass_idx]);
          chk("min_lower", int'(min_lower), exp_minl[pass_idx]);
          chk("max_larger", int'(max_larger), exp_maxg[pass_idx]);
          chk("min_larger", int'(min_larger), exp_ming[pass_idx]);
          chk("pivot_samp", int'(pivot_samp), exp_piv[pass_idx]);
          chk("median_pos_samp", int'(median_pos_samp), exp_pos[pass_idx]);
          chk("buff_size_samp", int'(buff_size_samp), exp_size[pass_idx]);
          chk("second_median_samp", int'(second_median_samp), exp_sm[pass_idx]);
        end
        pass_idx++;
      end
      if (out_valid) begin
        chk("median", int'(median), exp_median);
        chk("iter_err", int'(iter_err), exp_err);
        chk("busy_done", int'(busy), 1);
      end
      if (out_valid && !ov_prev) begin
        chk("passes", pass_idx, exp_passes);
        chk("latency", cyc - start_cyc, exp_passes * 1027);
      end
    end
    ov_prev = out_valid;
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_counts"}, int'(lower_size) + int'(equal_size) + int'(larger_size), 0);
    chk({tag, "_max_lower"}, int'(max_lower), 0);
    chk({tag, "_max_larger"}, int'(max_larger), 0);
    chk({tag, "_min_lower"}, int'(min_lower), 255);
    chk({tag, "_min_larger"}, int'(min_larger), 255);
    chk({tag, "_pivot"}, int'(pivot_samp), 127);
    chk({tag, "_second_median"}, int'(second_median_samp), 127);
    chk({tag, "_pos"}, int'(median_pos_samp), 512);
    chk({tag, "_size"}, int'(buff_size_samp), 1024);
    chk({tag, "_median"}, int'(median), 0);
    chk({tag, "_strobes"}, int'({out_valid, up_next, mem_rd_en, iter_err}), 0);
  endtask

  task automatic start_frame();
    pass_idx = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start_cyc = cyc; start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!out_valid && k < 5000) begin @(negedge clk); k++; end
    chk({tag, "_valid_seen"}, int'(out_valid), 1);
  endtask

  task automatic accept(input string tag, input int hold, input bit start_at_accept);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1; start = start_at_accept;
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0;
    chk({tag, "_valid_cleared"}, int'(out_valid), 0);
    chk({tag, "_idle"}, int'(busy), 0);
    chk({tag, "_err_cleared"}, int'(iter_err), 0);
    @(negedge clk);
    chk({tag, "_still_idle"}, int'(busy), 0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    @(negedge clk);

    // All samples equal: found in one pass
    for (int i = 0; i < 1024; i++) mem[i] = 8'd50;
    model_run();
    chk("model_t1_median", exp_median, 50);
    chk("model_t1_passes", exp_passes, 1);
    check_en = 1'b1;
    start_frame();
    wait_valid("t1");
    chk("t1_median_lit", int'(median), 50);
    chk("t1_latency_lit", cyc - start_cyc, 1027);
    accept("t1", 0, 1'b0);

    // Interleaved 10/200: LARG then EQ0, median is the mean of the two middle samples
    for (int i = 0; i < 1024; i++) mem[i] = (i % 2 == 1) ? 8'd200 : 8'd10;
    model_run();
    chk("model_t2_l", exp_l[0], 512);
    chk("model_t2_e", exp_e[0], 0);
    chk("model_t2_g", exp_g[0], 512);
    chk("model_t2_median", exp_median, LIM ? 200 : 105);
    chk("model_t2_passes", exp_passes, LIM ? 1 : 2);
    chk("model_t2_err", exp_err, LIM ? 1 : 0);
    start_frame();
    wait_valid("t2");
    chk("t2_median_lit", int'(median), LIM ? 200 : 105);
    chk("t2_err_lit", int'(iter_err), LIM ? 1 : 0);
    accept("t2", 0, 1'b0);

    // Back-pressure: result held for 20 cycles, start at acceptance ignored
    start_frame();
    wait_valid("t3");
    accept("t3", 20, 1'b1);

    // Start pulsed mid-pass has no effect
    start_frame();
    repeat (100) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_valid("t4");
    chk("t4_median_lit", int'(median), LIM ? 200 : 105);
    accept("t4", 0, 1'b0);

    // Reset at address 300 of pass 1, then a clean frame
    start_frame();
    k = 0;
    while (!(mem_rd_en && mem_rd_addr == 10'd300) && k < 2000) begin @(negedge clk); k++; end
    chk("t5_addr300_seen", int'(mem_rd_addr), 300);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("postrst");
    start_frame();
    wait_valid("t5");
    chk("t5_median_lit", int'(median), LIM ? 200 : 105);
    accept("t5", 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
